// File: rtl/controle_acesso_perfil.sv
// controle_acesso_perfil: request front-end for the profile permission check.
// It captures profile/function, hands them to an external comparator, samples the
// verdict and answers via a req/ack handshake. After MAX_NEG consecutive denials
// the interface locks for LOCK_CYCLES cycles.
// Optional macro NEG_LOG_EN adds a log of the most recently denied request.
module controle_acesso_perfil #(
    parameter int MAX_NEG     = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] perfil,
    input  logic [2:0] funcao,
    input  logic       perm_ok,
    output logic [2:0] perfil_out,
    output logic [2:0] funcao_out,
    output logic       ack,
    output logic       concedido,
    output logic       negado,
    output logic       bloqueado,
    output logic [3:0] cnt_neg
`ifdef NEG_LOG_EN
    ,
    output logic [2:0] ult_perfil,
    output logic [2:0] ult_funcao,
    output logic       ult_valido
`endif
);

    localparam logic [3:0] MAX_NEG_C   = 4'(MAX_NEG);
    localparam logic [7:0] LOCK_INIT_C = 8'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        AVALIA   = 2'd1,
        RESPOSTA = 2'd2,
        BLOQUEIO = 2'd3
    } estado_t;

    estado_t    state_q, state_d;
    logic       settle_q, settle_d;
    logic [2:0] perfil_q, perfil_d;
    logic [2:0] funcao_q, funcao_d;
    logic       ack_q, ack_d;
    logic       concedido_q, concedido_d;
    logic       negado_q, negado_d;
    logic       bloqueado_q, bloqueado_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] lock_q, lock_d;
`ifdef NEG_LOG_EN
    logic [2:0] ult_perfil_q, ult_perfil_d;
    logic [2:0] ult_funcao_q, ult_funcao_d;
    logic       ult_valido_q, ult_valido_d;
`endif

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCIOSO;
            settle_q    <= 1'b0;
            perfil_q    <= '0;
            funcao_q    <= '0;
            ack_q       <= 1'b0;
            concedido_q <= 1'b0;
            negado_q    <= 1'b0;
            bloqueado_q <= 1'b0;
            cnt_q       <= '0;
            lock_q      <= '0;
`ifdef NEG_LOG_EN
            ult_perfil_q <= '0;
            ult_funcao_q <= '0;
            ult_valido_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            perfil_q    <= perfil_d;
            funcao_q    <= funcao_d;
            ack_q       <= ack_d;
            concedido_q <= concedido_d;
            negado_q    <= negado_d;
            bloqueado_q <= bloqueado_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
`ifdef NEG_LOG_EN
            ult_perfil_q <= ult_perfil_d;
            ult_funcao_q <= ult_funcao_d;
            ult_valido_q <= ult_valido_d;
`endif
        end
    end

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        perfil_d    = perfil_q;
        funcao_d    = funcao_q;
        ack_d       = ack_q;
        concedido_d = concedido_q;
        negado_d    = negado_q;
        bloqueado_d = bloqueado_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q;
`ifdef NEG_LOG_EN
        ult_perfil_d = ult_perfil_q;
        ult_funcao_d = ult_funcao_q;
        ult_valido_d = ult_valido_q;
`endif
        case (state_q)
            OCIOSO: begin
                if (req) begin
                    perfil_d = perfil;
                    funcao_d = funcao;
                    settle_d = 1'b0;
                    state_d  = AVALIA;
                end
            end
            AVALIA: begin
                // First edge only lets the comparator settle on the new fields;
                // the verdict is sampled on the second, giving ack two edges
                // after capture.
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else begin
                    state_d = RESPOSTA;
                    ack_d   = 1'b1;
                    if (perm_ok) begin
                        concedido_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        negado_d = 1'b1;
                        cnt_d    = (cnt_q >= MAX_NEG_C) ? MAX_NEG_C : cnt_q + 4'd1;
`ifdef NEG_LOG_EN
                        ult_perfil_d = perfil_q;
                        ult_funcao_d = funcao_q;
                        ult_valido_d = 1'b1;
`endif
                    end
                end
            end
            RESPOSTA: begin
                if (!req) begin
                    ack_d       = 1'b0;
                    concedido_d = 1'b0;
                    negado_d    = 1'b0;
                    if (cnt_q == MAX_NEG_C) begin
                        state_d     = BLOQUEIO;
                        bloqueado_d = 1'b1;
                        lock_d      = LOCK_INIT_C;
                    end else begin
                        state_d = OCIOSO;
                    end
                end
            end
            BLOQUEIO: begin
                // Requests are ignored here; counter runs LOCK_CYCLES-1 down to 0.
                if (lock_q == 8'd0) begin
                    bloqueado_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = OCIOSO;
                end else begin
                    lock_d = lock_q - 8'd1;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    assign perfil_out = perfil_q;
    assign funcao_out = funcao_q;
    assign ack        = ack_q;
    assign concedido  = concedido_q;
    assign negado     = negado_q;
    assign bloqueado  = bloqueado_q;
    assign cnt_neg    = cnt_q;
`ifdef NEG_LOG_EN
    assign ult_perfil = ult_perfil_q;
    assign ult_funcao = ult_funcao_q;
    assign ult_valido = ult_valido_q;
`endif

endmodule

// File: tb/tb_controle_acesso_perfil.sv
// Bench for controle_acesso_perfil: directed requests, expected responses queued
// by the driver and checked by an independent monitor when ack rises.
module tb_controle_acesso_perfil;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [2:0] perfil = '0;
    logic [2:0] funcao = '0;
    logic       perm_ok;
    logic [2:0] perfil_out, funcao_out;
    logic       ack, concedido, negado, bloqueado;
    logic [3:0] cnt_neg;
`ifdef NEG_LOG_EN
    logic [2:0] ult_perfil, ult_funcao;
    logic       ult_valido;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mcnt   = 0;
    logic [11:0] sb[$];
    logic ack_prev = 1'b0;

    controle_acesso_perfil #(.MAX_NEG(3), .LOCK_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .perfil(perfil), .funcao(funcao),
        .perm_ok(perm_ok), .perfil_out(perfil_out), .funcao_out(funcao_out),
        .ack(ack), .concedido(concedido), .negado(negado), .bloqueado(bloqueado),
        .cnt_neg(cnt_neg)
`ifdef NEG_LOG_EN
        , .ult_perfil(ult_perfil), .ult_funcao(ult_funcao), .ult_valido(ult_valido)
`endif
    );

    always #5 clk = ~clk;

    // Reference comparator: c&~d&~e or a&~b&~f grants access.
    function automatic logic perm_fn(input logic [2:0] p, input logic [2:0] f);
        return (p[0] & ~f[2] & ~f[1]) | (p[2] & ~p[1] & ~f[0]);
    endfunction

    assign perm_ok = perm_fn(perfil_out, funcao_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one response per ack rising edge.
    always @(negedge clk) begin
        if (ack && !ack_prev) begin
            if (sb.size() == 0) begin
                chk("ack_inesperado", 32'(ack), 32'd0);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                chk("resposta", 32'({concedido, negado, cnt_neg, perfil_out, funcao_out}), 32'(e));
                $display("resp: perfil=%b funcao=%b conc=%b neg=%b cnt=%0d", perfil_out, funcao_out,
                         concedido, negado, cnt_neg);
            end
        end
        ack_prev = ack;
    end

    task automatic push_exp(input logic [2:0] p, input logic [2:0] f);
        logic g;
        g = perm_fn(p, f);
        if (g) mcnt = 0;
        else if (mcnt < 3) mcnt++;
        sb.push_back({g, ~g, 4'(mcnt), p, f});
    endtask

    // Waits for ack, counting negedges; optionally scrambles inputs after capture.
    task automatic wait_ack(input bit scramble, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && n == 1) begin
                perfil = ~perfil;
                funcao = ~funcao;
            end
        end while (!ack && n < 200);
    endtask

    task automatic do_req(input logic [2:0] p, input logic [2:0] f);
        int n;
        @(negedge clk);
        perfil = p; funcao = f; req = 1'b1;
        push_exp(p, f);
        wait_ack(1'b1, n);
        chk("latencia", 32'(n), 32'd3);
        req = 1'b0;
        @(negedge clk);
        chk("ack_baixo", 32'(ack), 32'd0);
        chk("bloqueado_pos_resp", 32'(bloqueado), 32'(mcnt == 3));
    endtask

    task automatic check_lock();
        int n;
        n = 0;
        while (bloqueado && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("duracao_bloqueio", 32'(n), 32'd16);
        chk("cnt_pos_bloqueio", 32'(cnt_neg), 32'd0);
        mcnt = 0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 chk("reset_assinc", 32'({perfil_out, funcao_out, ack, concedido, negado, bloqueado, cnt_neg}), 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mcnt = 0;
    endtask

    initial begin
        int n;
        bit ack_lock;
        repeat (2) @(negedge clk);
        chk("reset", 32'({perfil_out, funcao_out, ack, concedido, negado, bloqueado, cnt_neg}), 32'd0);
        rst_n = 1'b1;

        // Grant, then three denials into lockout.
        do_req(3'b001, 3'b000);
        repeat (3) do_req(3'b000, 3'b101);
        check_lock();

        // Two denials, grant clears the count, two more denials: no lockout.
        repeat (2) do_req(3'b000, 3'b101);
        do_req(3'b100, 3'b000);
        repeat (2) do_req(3'b000, 3'b101);
        chk("sem_bloqueio", 32'(bloqueado), 32'd0);

        // Third denial with req re-raised and held through the lockout.
        do_req(3'b000, 3'b101);
        perfil = 3'b001; funcao = 3'b000; req = 1'b1;
        mcnt = 0;
        push_exp(3'b001, 3'b000);
        n = 0; ack_lock = 1'b0;
        while (bloqueado && n < 300) begin
            n++;
            if (ack) ack_lock = 1'b1;
            @(negedge clk);
        end
        chk("duracao_bloqueio_req", 32'(n), 32'd16);
        chk("ack_em_bloqueio", 32'(ack_lock), 32'd0);
        wait_ack(1'b0, n);
        chk("latencia_pos_bloqueio", 32'(n), 32'd3);
        req = 1'b0;
        @(negedge clk);
        chk("ack_baixo", 32'(ack), 32'd0);

        // Reset while in AVALIA.
        @(negedge clk);
        perfil = 3'b000; funcao = 3'b101; req = 1'b1;
        @(negedge clk);
        pulse_reset();
        do_req(3'b001, 3'b000);

        // Reset while locked.
        repeat (3) do_req(3'b000, 3'b101);
        repeat (4) @(negedge clk);
        pulse_reset();
        chk("bloq_pos_reset", 32'(bloqueado), 32'd0);
        do_req(3'b100, 3'b000);

`ifdef NEG_LOG_EN
        do_req(3'b010, 3'b011);
        chk("log_negacao", 32'({ult_perfil, ult_funcao, ult_valido}), 32'({3'b010, 3'b011, 1'b1}));
        do_req(3'b001, 3'b000);
        chk("log_pos_concessao", 32'({ult_perfil, ult_funcao, ult_valido}), 32'({3'b010, 3'b011, 1'b1}));
`endif

        repeat (2) @(negedge clk);
        chk("fila_vazia", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_acesso_perfil.md
Name: controle_acesso_perfil

Overview:
Sequential request front-end for the interface-1 profile permission check.
- Accepts an access request carrying a 3-bit profile and a 3-bit function code.
- Registers both fields and drives them to the downstream combinational permission comparator.
- Samples the comparator verdict and returns grant or deny through a req/ack handshake.
- Counts consecutive denials and locks the interface for a fixed time once a threshold is reached.

Parameters:
MAX_NEG, 3, consecutive denials that trigger lockout (1..15)
LOCK_CYCLES, 16, lockout duration in clock cycles (2..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  access request, level; held high until ack seen
perfil  input  3  requesting profile {a,b,c}; perfil[2]=a
funcao  input  3  requested function {d,e,f}; funcao[2]=d
perm_ok  input  1  verdict from permission comparator, combinational on perfil_out/funcao_out
perfil_out  output  3  registered profile driven to comparator
funcao_out  output  3  registered function driven to comparator
ack  output  1  response valid
concedido  output  1  access granted; valid only while ack=1
negado  output  1  access denied; valid only while ack=1
bloqueado  output  1  interface locked
cnt_neg  output  4  consecutive-denial count

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; all outputs 0; internal lock counter 0.
- Interface timing: clk only, one clock domain; rst_n asynchronous, active-low.
- OCIOSO: on a rising edge with req=1, load perfil_out<=perfil and funcao_out<=funcao, then go to AVALIA.
- AVALIA: lasts one cycle so the comparator settles. At the edge, sample perm_ok into the result and go to RESPOSTA.
  - perm_ok=1: concedido<=1 and cnt_neg<=0.
  - perm_ok=0: negado<=1 and cnt_neg<=cnt_neg+1, saturating at MAX_NEG.
- RESPOSTA: ack=1 with exactly one of concedido/negado set; perfil_out/funcao_out stable.
  - Outputs hold while req=1.
  - On the edge with req=0: clear ack/concedido/negado.
  - If cnt_neg==MAX_NEG, go to BLOQUEIO and load the lock counter with LOCK_CYCLES-1; otherwise go to OCIOSO.
- Latency: req sampled high at edge N gives ack=1 after edge N+2. The earliest next capture is at edge N+4 (req low at N+3).
- BLOQUEIO: bloqueado=1 and req is ignored; the lock counter decrements each cycle. bloqueado is high for exactly LOCK_CYCLES cycles.
  - The edge where the counter is 0 clears bloqueado, clears cnt_neg and goes to OCIOSO.
  - If req is still high at that point, it is captured on the next edge as a new request.
- Input changes: perfil/funcao changes after capture have no effect until the next OCIOSO capture.
- req drop before ack: if req drops in AVALIA, the response is still produced. RESPOSTA is then exited on the first edge, so ack is high for exactly 1 cycle and the denial is still counted.
- Reset mid-operation: any state returns to OCIOSO immediately; the lockout and the count are lost.
- Outputs are all registered; no combinational path from req or perm_ok to any output.

Optional Feature:
Macro NEG_LOG_EN.
- Defined: adds outputs ult_perfil[2:0], ult_funcao[2:0] and ult_valido. On every denial, these load perfil_out/funcao_out at the AVALIA edge and set ult_valido=1. They reset to 0 and are not cleared by lockout or grants.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then perfil=3'b001, funcao=3'b000 (c=1,d=0,e=0, permitted), req=1 -> ack=1 and concedido=1 two edges later; cnt_neg=0; after req=0, ack=0 next edge.
- perfil=3'b000, funcao=3'b101 (no rule satisfied) -> negado=1, cnt_neg=1; repeated 3 times -> cnt_neg=3, bloqueado=1 for exactly 16 cycles, then cnt_neg=0.
- Two denials, then perfil=3'b100, funcao=3'b000 (a=1,b=0,f=0, permitted) -> concedido=1, cnt_neg=0; no lockout after a further two denials.
- req held high throughout lockout -> no ack during BLOQUEIO; capture occurs on the edge after bloqueado falls.
- rst_n pulsed low mid-AVALIA and mid-BLOQUEIO -> all outputs 0 asynchronously, state OCIOSO; next request is handled normally.
- With NEG_LOG_EN: denial of perfil=3'b010, funcao=3'b011 -> ult_perfil=3'b010, ult_funcao=3'b011, ult_valido=1; unchanged after a following grant.
